// File: rtl/wptr_handler_lvl.sv
// wptr_handler_lvl
// Write-side pointer controller for a dual-clock FIFO, in the write clock domain.
// It advances the binary and Gray write pointers on accepted writes. From the
// synchronised Gray read pointer it produces a registered full flag, the fill
// level, an almost-full flag and a sticky overflow error.
//
// Ports:
//   wclk         write-domain clock, rising edge
//   wrst         synchronous active-low reset
//   w_en         write request this cycle
//   g_rptr_sync  Gray read pointer, already synchronised into wclk
//   ovf_clr      clears the sticky overflow flag (a same-cycle set wins)
//   w_accept     combinational write qualifier, w_en & ~full
//   waddr        RAM write address (low bits of b_wptr)
//   b_wptr       registered binary write pointer
//   g_wptr       registered Gray write pointer
//   full         registered full flag
//   almost_full  registered, wlevel >= AFULL_THRESH
//   wlevel       registered occupancy, 0..2**PTR_WIDTH
//   overflow     sticky flag, set by a write attempt while full
module wptr_handler_lvl #(
  parameter int PTR_WIDTH    = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 w_en,
  input  logic [PTR_WIDTH:0]   g_rptr_sync,
  input  logic                 ovf_clr,
  output logic                 w_accept,
  output logic [PTR_WIDTH-1:0] waddr,
  output logic [PTR_WIDTH:0]   b_wptr,
  output logic [PTR_WIDTH:0]   g_wptr,
  output logic                 full,
  output logic                 almost_full,
  output logic [PTR_WIDTH:0]   wlevel,
  output logic                 overflow
);

  localparam logic [PTR_WIDTH:0] AFULL_T = (PTR_WIDTH+1)'(AFULL_THRESH);

  logic [PTR_WIDTH:0] b_wptr_q, b_wptr_d;
  logic [PTR_WIDTH:0] g_wptr_q, g_wptr_d;
  logic [PTR_WIDTH:0] wlevel_q, wlevel_d;
  logic               full_q, full_d;
  logic               afull_q, afull_d;
  logic               ovf_q, ovf_d;
  logic [PTR_WIDTH:0] rbin;

  // Gray-to-binary decode of the synchronised read pointer, MSB downwards.
  always_comb begin
    rbin            = '0;
    rbin[PTR_WIDTH] = g_rptr_sync[PTR_WIDTH];
    for (int unsigned i = PTR_WIDTH; i > 0; i--) begin
      rbin[i-1] = rbin[i] ^ g_rptr_sync[i-1];
    end
  end

  always_comb begin
    w_accept = w_en & ~full_q;
    b_wptr_d = b_wptr_q + (PTR_WIDTH+1)'(w_accept);
    g_wptr_d = (b_wptr_d >> 1) ^ b_wptr_d;
    // Full when the write pointer is exactly one lap ahead of the read pointer:
    // in Gray code that means the top two bits are inverted, the rest equal.
    full_d   = (g_wptr_d == {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1],
                             g_rptr_sync[PTR_WIDTH-2:0]});
    wlevel_d = b_wptr_d - rbin;
    afull_d  = (wlevel_d >= AFULL_T);
    ovf_d    = ovf_q;
    if (w_en & full_q) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst) begin
      b_wptr_q <= '0;
      g_wptr_q <= '0;
      wlevel_q <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      b_wptr_q <= b_wptr_d;
      g_wptr_q <= g_wptr_d;
      wlevel_q <= wlevel_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
    end
  end

  assign waddr       = b_wptr_q[PTR_WIDTH-1:0];
  assign b_wptr      = b_wptr_q;
  assign g_wptr      = g_wptr_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign wlevel      = wlevel_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_wptr_handler_lvl.sv
module tb_wptr_handler_lvl;

  localparam int PW = 3;
  localparam int D  = 1 << PW;
  localparam int M2 = 2 * D;
  localparam int T  = 6;

  logic          wclk = 1'b0;
  logic          wrst;
  logic          w_en;
  logic          ovf_clr;
  logic [PW:0]   g_rptr_sync;
  logic          w_accept;
  logic [PW-1:0] waddr;
  logic [PW:0]   b_wptr, g_wptr, wlevel;
  logic          full, almost_full, overflow;

  // second instance for the parameter sweep
  logic          w_en2;
  logic [2:0]    g_rptr2;
  logic          w_accept2;
  logic [1:0]    waddr2;
  logic [2:0]    b_wptr2, g_wptr2, wlevel2;
  logic          full2, almost_full2, overflow2;

  int r_bin;
  int checks   = 0;
  int failures = 0;

  always #5 wclk = ~wclk;

  always_comb g_rptr_sync = (PW+1)'(r_bin ^ (r_bin >> 1));

  wptr_handler_lvl #(.PTR_WIDTH(PW), .AFULL_THRESH(T)) u_dut (
    .wclk(wclk), .wrst(wrst), .w_en(w_en), .g_rptr_sync(g_rptr_sync),
    .ovf_clr(ovf_clr), .w_accept(w_accept), .waddr(waddr), .b_wptr(b_wptr),
    .g_wptr(g_wptr), .full(full), .almost_full(almost_full), .wlevel(wlevel),
    .overflow(overflow)
  );

  wptr_handler_lvl #(.PTR_WIDTH(2), .AFULL_THRESH(4)) u_dut2 (
    .wclk(wclk), .wrst(wrst), .w_en(w_en2), .g_rptr_sync(g_rptr2),
    .ovf_clr(1'b0), .w_accept(w_accept2), .waddr(waddr2), .b_wptr(b_wptr2),
    .g_wptr(g_wptr2), .full(full2), .almost_full(almost_full2), .wlevel(wlevel2),
    .overflow(overflow2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: write count modulo two laps, occupancy as the distance
  // from the read pointer the bench drives.
  int  m_b = 0, m_level = 0;
  bit  m_full = 0, m_afull = 0, m_ovf = 0, m_valid = 0;
  int  acc, nb, lvl;

  always @(posedge wclk) begin
    m_valid <= 1'b1;
    if (!wrst) begin
      m_b <= 0; m_level <= 0; m_full <= 0; m_afull <= 0; m_ovf <= 0;
    end else begin
      acc = (w_en && !m_full) ? 1 : 0;
      nb  = (m_b + acc) % M2;
      lvl = (nb - r_bin + M2) % M2;
      m_b     <= nb;
      m_level <= lvl;
      m_full  <= (lvl == D);
      m_afull <= (lvl >= T);
      if (w_en && m_full) m_ovf <= 1'b1;
      else if (ovf_clr)   m_ovf <= 1'b0;
    end
  end

  // Compare process: every cycle, half a period after the edge.
  int prev_b = 0, prev_g = 0;
  bit have_prev = 0;

  always @(negedge wclk) begin
    if (m_valid) begin
      chk("w_accept",    int'(w_accept),    int'(w_en && !m_full));
      chk("b_wptr",      int'(b_wptr),      m_b);
      chk("waddr",       int'(waddr),       m_b % D);
      chk("g_wptr",      int'(g_wptr),      m_b ^ (m_b >> 1));
      chk("wlevel",      int'(wlevel),      m_level);
      chk("full",        int'(full),        int'(m_full));
      chk("almost_full", int'(almost_full), int'(m_afull));
      chk("overflow",    int'(overflow),    int'(m_ovf));
      if (have_prev && int'(b_wptr) == (prev_b + 1) % M2)
        chk("gray_step_bits", $countones(g_wptr ^ (PW+1)'(prev_g)), 1);
      prev_b    = int'(b_wptr);
      prev_g    = int'(g_wptr);
      have_prev = 1'b1;
    end
  end

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  initial begin
    wrst = 1'b0; w_en = 1'b1; ovf_clr = 1'b0; r_bin = 0;
    w_en2 = 1'b0; g_rptr2 = '0;

    // reset held with writes requested
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_b_wptr", int'(b_wptr), 0);
      chk("rst_wlevel", int'(wlevel), 0);
      chk("rst_flags", int'({full, almost_full, overflow}), 0);
    end
    wrst = 1'b1; w_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("idle_b_wptr", int'(b_wptr), 0);
    end

    // fill with 10 writes, read pointer at 0
    w_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("fill_wlevel",   int'(wlevel),      (k > 8) ? 8 : k);
      chk("fill_afull",    int'(almost_full), int'(k >= 6));
      chk("fill_full",     int'(full),        int'(k >= 8));
      chk("fill_overflow", int'(overflow),    int'(k >= 9));
    end
    chk("fill_b_wptr", int'(b_wptr), 8);
    chk("fill_g_wptr", int'(g_wptr), 12);

    // overflow clear: set wins over clear, then clear alone
    ovf_clr = 1'b1;
    step();
    chk("ovf_set_wins", int'(overflow), 1);
    w_en = 1'b0;
    step();
    chk("ovf_cleared", int'(overflow), 0);
    ovf_clr = 1'b0;

    // drain and wrap while writing continuously
    w_en = 1'b1;
    for (int r = 1; r <= 8; r++) begin
      r_bin = r;
      step();
    end
    for (int i = 0; i < 8; i++) step();

    // level decode: b_wptr=13 against read pointer 9
    wrst = 1'b0; r_bin = 0; w_en = 1'b0;
    step();
    wrst = 1'b1; w_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      r_bin = (i >= 5) ? i - 4 : 0;
      step();
    end
    w_en = 1'b0; r_bin = 9;
    step();
    chk("dec_b_wptr", int'(b_wptr), 13);
    chk("dec_wlevel", int'(wlevel), 4);
    chk("dec_flags",  int'({full, almost_full}), 0);

    // randomized traffic with occasional mid-run reset
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        wrst = 1'b0; r_bin = 0;
      end else begin
        wrst = 1'b1;
        if (r_bin != m_b && $urandom_range(0, 1) == 1) r_bin = (r_bin + 1) % M2;
      end
      w_en    = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      step();
    end

    // parameter sweep: PTR_WIDTH=2, AFULL_THRESH=4
    wrst = 1'b0; r_bin = 0; w_en = 1'b0; ovf_clr = 1'b0;
    step();
    wrst = 1'b1; w_en2 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("p2_wlevel",   int'(wlevel2),      (k > 4) ? 4 : k);
      chk("p2_full",     int'(full2),        int'(k >= 4));
      chk("p2_afull",    int'(almost_full2), int'(k >= 4));
      chk("p2_overflow", int'(overflow2),    int'(k >= 5));
    end
    chk("p2_b_wptr", int'(b_wptr2), 4);
    chk("p2_g_wptr", int'(g_wptr2), 6);
    w_en2 = 1'b0;

    @(negedge wclk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wptr_handler_lvl.md
# wptr_handler_lvl

Write-side pointer controller for the dual-clock FIFO, in the write clock domain. It advances the binary and Gray write pointers on accepted writes, and produces a registered full flag from the synchronised Gray read pointer. Over the basic write-pointer handler it adds a decoded fill level, a programmable almost-full flag and a sticky overflow error. The AXI-facing producer uses almost-full for back-pressure, and the AXI-facing side uses the fill level for burst sizing.

## Interface
- PTR_WIDTH, 3: address width. FIFO depth = 2**PTR_WIDTH. Pointers are PTR_WIDTH+1 bits. Legal range is 2..8.
- AFULL_THRESH, 6: fill level at or above which almost_full asserts. Legal range is 1..2**PTR_WIDTH.
- wclk  in  1  write-domain clock. All logic is on the rising edge.
- wrst  in  1  synchronous, active-low reset, sampled on the rising edge of wclk.
- w_en  in  1  write request for this cycle.
- g_rptr_sync  in  PTR_WIDTH+1  Gray read pointer, already 2-flop synchronised into wclk.
- ovf_clr  in  1  clears the overflow flag.
- w_accept  out  1  combinational, = w_en & ~full. Qualifies the RAM write this cycle.
- waddr  out  PTR_WIDTH  = b_wptr[PTR_WIDTH-1:0]. RAM write address.
- b_wptr  out  PTR_WIDTH+1  binary write pointer, registered.
- g_wptr  out  PTR_WIDTH+1  Gray write pointer, registered. Goes to the read-domain synchroniser.
- full  out  1  registered full flag.
- almost_full  out  1  registered, = (wlevel >= AFULL_THRESH).
- wlevel  out  PTR_WIDTH+1  registered occupancy, range 0..2**PTR_WIDTH.
- overflow  out  1  sticky, registered. Set by a write attempt while full.

## Operation
- Next-state values:
  - b_next = b_wptr + w_accept, modulo 2**(PTR_WIDTH+1). The extra MSB toggles on each wrap.
  - g_next = (b_next >> 1) ^ b_next.
- Read pointer decode is combinational: rbin[PTR_WIDTH] = g_rptr_sync[PTR_WIDTH], and rbin[i] = rbin[i+1] ^ g_rptr_sync[i] for i down to 0.
- Full detection: full_next = (g_next == {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]}).
- Level: lvl_next = b_next - rbin, an unsigned subtraction in PTR_WIDTH+1 bits. It is never greater than 2**PTR_WIDTH. lvl_next == 2**PTR_WIDTH exactly when full_next = 1.
- Almost-full: afull_next = (lvl_next >= AFULL_THRESH).
- Register update each rising edge of wclk with wrst = 1: b_wptr, g_wptr, full, wlevel and almost_full load their _next values.
- overflow update:
  - set when w_en & full;
  - otherwise cleared when ovf_clr;
  - otherwise holds.
  - If set and clear occur in the same cycle, set wins.
- A write while full is dropped: the pointers hold and w_accept = 0.
- Reset: on a rising edge with wrst = 0, b_wptr, g_wptr, full, almost_full, wlevel and overflow all go to 0, regardless of w_en or ovf_clr. Reset applies mid-operation in the same way. The read domain must be reset together with this block.

## Timing
- Pointer latency: one cycle. An accept at edge N is visible on b_wptr/g_wptr after edge N.
- full, wlevel and almost_full reflect the state after that edge's write, measured against the g_rptr_sync sampled at that edge.
- Read-side frees reach wlevel and full 1 cycle after g_rptr_sync changes. End to end this is 3 wclk cycles counting the synchroniser. The flags are conservative and can never under-report.
- g_wptr changes exactly one bit per accepted write, including across the wrap from 2**(PTR_WIDTH+1)-1 to 0.
- Back-to-back writes are accepted every cycle until full, with no bubble.

## Test plan
All scenarios use PTR_WIDTH=3 and AFULL_THRESH=6 unless stated.
- Reset: hold wrst=0 with w_en=1 for 3 cycles → all registered outputs are 0 and w_accept=1. After release with w_en=0, everything stays 0.
- Fill: g_rptr_sync=0, w_en=1 for 10 cycles.
  - wlevel steps 1..8.
  - almost_full rises after the 6th accept.
  - full rises after the 8th accept.
  - b_wptr=8, g_wptr=4'b1100.
  - Accepts 9 and 10 are dropped; overflow=1 from the 9th edge.
- Overflow clear: with overflow=1 and full=1, assert ovf_clr and w_en together → overflow stays 1. Assert ovf_clr alone → overflow=0 the next cycle.
- Drain and wrap: start full, step g_rptr_sync through the Gray codes of 1..8 while writing continuously.
  - The pointer wraps 15→0 with a single Gray bit change.
  - wlevel holds at 8 or 7 with no underflow.
  - full toggles correctly.
- Level decode: b_wptr=13, g_rptr_sync=Gray(9)=4'b1101 → wlevel=4, almost_full=0, full=0.
- Parameter sweep: repeat the fill scenario with PTR_WIDTH=2 and AFULL_THRESH=4 → full and almost_full both assert after the 4th accept.
